// File: rtl/rob_if.sv
// -----------------------------------------------------------------------------
// rob_if
// Bundles the reorder buffer's dispatch, CDB, query, commit and occupancy
// signals so they can be passed around as a single port.
//
// Modports
//   slave  : the reorder buffer itself (receives dispatch/CDB/query inputs,
//            drives allocation, query, commit and count outputs)
//   master : the surrounding pipeline / testbench (the mirror image)
//
// Optional: ROB_FLUSH_EN adds the 1-bit flush signal.
// -----------------------------------------------------------------------------
interface rob_if #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 4
);
`ifdef ROB_FLUSH_EN
    logic                     flush;
`endif
    // dispatch / allocation
    logic                     alloc_valid;
    logic [4:0]               alloc_rd_index;
    logic                     alloc_ready;
    logic [ROB_TAG_WIDTH-1:0] alloc_tag;
    logic                     rob_entry_alloc;
    // common data bus
    logic                     cdb_valid;
    logic [ROB_TAG_WIDTH-1:0] cdb_tag;
    logic [XLEN-1:0]          cdb_data;
    // operand lookup
    logic [ROB_TAG_WIDTH-1:0] query1_tag;
    logic [ROB_TAG_WIDTH-1:0] query2_tag;
    logic                     query1_ready;
    logic                     query2_ready;
    logic [XLEN-1:0]          query1_value;
    logic [XLEN-1:0]          query2_value;
    // in-order retirement
    logic                     commit_valid;
    logic                     commit_write_en;
    logic [4:0]               commit_rd_index;
    logic [XLEN-1:0]          commit_data;
    logic [ROB_TAG_WIDTH-1:0] commit_tag;
    logic [ROB_TAG_WIDTH:0]   count;

    modport slave (
`ifdef ROB_FLUSH_EN
        input  flush,
`endif
        input  alloc_valid, alloc_rd_index,
        input  cdb_valid, cdb_tag, cdb_data,
        input  query1_tag, query2_tag,
        output alloc_ready, alloc_tag, rob_entry_alloc,
        output query1_ready, query2_ready, query1_value, query2_value,
        output commit_valid, commit_write_en, commit_rd_index, commit_data, commit_tag,
        output count
    );

    modport master (
`ifdef ROB_FLUSH_EN
        output flush,
`endif
        output alloc_valid, alloc_rd_index,
        output cdb_valid, cdb_tag, cdb_data,
        output query1_tag, query2_tag,
        input  alloc_ready, alloc_tag, rob_entry_alloc,
        input  query1_ready, query2_ready, query1_value, query2_value,
        input  commit_valid, commit_write_en, commit_rd_index, commit_data, commit_tag,
        input  count
    );
endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular reorder buffer: hands out tags to dispatched instructions, captures
// results from the CDB, answers tag-indexed operand lookups, and retires
// results strictly in program order (one per cycle).
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-low reset
//   rob   : rob_if.slave bundle
//           alloc_valid/alloc_rd_index -> alloc_ready/alloc_tag/rob_entry_alloc
//           cdb_valid/cdb_tag/cdb_data  (result capture)
//           query{1,2}_tag -> query{1,2}_ready/query{1,2}_value
//           commit_valid/commit_write_en/commit_rd_index/commit_data/commit_tag
//           count (occupied entries, 0..2**ROB_TAG_WIDTH)
//
// Build option: define ROB_FLUSH_EN to add rob.flush, which empties the
// buffer and overrides allocation, capture and commit in that cycle.
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 4
) (
    input logic  clk,
    input logic  reset,
    rob_if.slave rob
);
    localparam int                     ROB_SIZE   = 1 << ROB_TAG_WIDTH;
    localparam logic [ROB_TAG_WIDTH:0] FULL_COUNT = (ROB_TAG_WIDTH+1)'(ROB_SIZE);

    // control state (reset)
    logic [ROB_SIZE-1:0]      valid_q, valid_d;
    logic [ROB_SIZE-1:0]      ready_q, ready_d;
    logic [ROB_TAG_WIDTH-1:0] head_q, head_d;
    logic [ROB_TAG_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_TAG_WIDTH:0]   count_q, count_d;

    // payload state (no reset; only meaningful while the entry is valid)
    logic [4:0]               rd_q    [ROB_SIZE];
    logic [XLEN-1:0]          value_q [ROB_SIZE];

    logic flush_w;
    logic alloc_ready_w;
    logic alloc_fire;
    logic commit_fire;
    logic cdb_hit;

`ifdef ROB_FLUSH_EN
    assign flush_w = rob.flush;
`else
    assign flush_w = 1'b0;
`endif

    // Full is judged on registered count only; a commit in the same cycle
    // does not open a slot until the next cycle.
    assign alloc_ready_w = (count_q != FULL_COUNT);
    assign alloc_fire    = rob.alloc_valid && alloc_ready_w;
    assign commit_fire   = valid_q[head_q] && ready_q[head_q] && !flush_w;
    assign cdb_hit       = rob.cdb_valid && valid_q[rob.cdb_tag];

    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_w) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_hit) begin
                ready_d[rob.cdb_tag] = 1'b1;
            end
            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
            end
            // tail never equals head while both fire: that needs an empty
            // buffer (no commit) or a full one (no allocation).
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                ready_d[tail_q] = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_q[tail_q] <= rob.alloc_rd_index;
        end
        if (cdb_hit) begin
            value_q[rob.cdb_tag] <= rob.cdb_data;
        end
    end

    assign rob.alloc_ready     = alloc_ready_w;
    assign rob.alloc_tag       = tail_q;
    assign rob.rob_entry_alloc = alloc_fire;

    assign rob.query1_ready    = valid_q[rob.query1_tag] && ready_q[rob.query1_tag];
    assign rob.query2_ready    = valid_q[rob.query2_tag] && ready_q[rob.query2_tag];
    assign rob.query1_value    = value_q[rob.query1_tag];
    assign rob.query2_value    = value_q[rob.query2_tag];

    assign rob.commit_valid    = commit_fire;
    assign rob.commit_write_en = commit_fire && (rd_q[head_q] != 5'd0);
    assign rob.commit_rd_index = rd_q[head_q];
    assign rob.commit_data     = value_q[head_q];
    assign rob.commit_tag      = head_q;
    assign rob.count           = count_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Scoreboard bench for reorder_buffer. A reference model keeps the in-flight
// instructions as a program-order queue of records; whenever the oldest record
// has its result it is announced into an expected-commit queue, which a
// negedge monitor pops when the DUT presents a commit. Directed scenarios are
// followed by a long randomized run with occasional resets (and flushes when
// ROB_FLUSH_EN is defined).
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
    localparam int XLEN = 32;
    localparam int TW   = 4;
    localparam int SIZE = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rob_if #(.XLEN(XLEN), .ROB_TAG_WIDTH(TW)) bus ();

    reorder_buffer #(.XLEN(XLEN), .ROB_TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (bus)
    );

`ifdef ROB_FLUSH_EN
    wire flush_now = bus.flush;
`else
    wire flush_now = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [TW-1:0]   tag;
        logic [4:0]      rd;
        bit              done;
        logic [XLEN-1:0] data;
        bit              ann;
    } ent_t;

    typedef struct {
        logic [TW-1:0]   tag;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } cmt_t;

    ent_t rob_m[$];
    cmt_t exp_q[$];
    int   next_tag = 0;

    always @(negedge reset) begin
        rob_m.delete();
        exp_q.delete();
        next_tag = 0;
    end

    always @(posedge clk) begin
        bit   dc, da;
        ent_t n;
        cmt_t c;
        if (reset === 1'b1) begin
            if (flush_now) begin
                rob_m.delete();
                exp_q.delete();
                next_tag = 0;
            end else begin
                dc = (rob_m.size() > 0) && rob_m[0].done;
                da = bus.alloc_valid && (rob_m.size() != SIZE);
                if (bus.cdb_valid) begin
                    foreach (rob_m[i]) begin
                        if (rob_m[i].tag == bus.cdb_tag) begin
                            rob_m[i].done = 1'b1;
                            rob_m[i].data = bus.cdb_data;
                        end
                    end
                end
                if (dc) void'(rob_m.pop_front());
                if (da) begin
                    n.tag  = next_tag[TW-1:0];
                    n.rd   = bus.alloc_rd_index;
                    n.done = 1'b0;
                    n.data = '0;
                    n.ann  = 1'b0;
                    rob_m.push_back(n);
                    next_tag = (next_tag + 1) % SIZE;
                end
                if (rob_m.size() > 0 && rob_m[0].done && !rob_m[0].ann) begin
                    rob_m[0].ann = 1'b1;
                    c.tag  = rob_m[0].tag;
                    c.rd   = rob_m[0].rd;
                    c.data = rob_m[0].data;
                    exp_q.push_back(c);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int              sz;
        bit              ev, q1r, q2r;
        logic [XLEN-1:0] q1v, q2v;
        cmt_t            e;
        sz = rob_m.size();
        chk("count", bus.count, sz);
        chk("alloc_ready", bus.alloc_ready, sz != SIZE);
        chk("alloc_tag", bus.alloc_tag, next_tag);
        chk("rob_entry_alloc", bus.rob_entry_alloc, bus.alloc_valid && (sz != SIZE));
        ev = (exp_q.size() > 0) && !flush_now;
        chk("commit_valid", bus.commit_valid, ev);
        if (bus.commit_valid && ev) begin
            e = exp_q.pop_front();
            chk("commit_tag", bus.commit_tag, e.tag);
            chk("commit_rd_index", bus.commit_rd_index, e.rd);
            chk("commit_data", bus.commit_data, e.data);
            chk("commit_write_en", bus.commit_write_en, e.rd != 5'd0);
        end else begin
            chk("commit_write_en_idle", bus.commit_write_en, 1'b0);
        end
        q1r = 1'b0; q2r = 1'b0; q1v = '0; q2v = '0;
        foreach (rob_m[i]) begin
            if (rob_m[i].tag == bus.query1_tag && rob_m[i].done) begin
                q1r = 1'b1; q1v = rob_m[i].data;
            end
            if (rob_m[i].tag == bus.query2_tag && rob_m[i].done) begin
                q2r = 1'b1; q2v = rob_m[i].data;
            end
        end
        chk("query1_ready", bus.query1_ready, q1r);
        chk("query2_ready", bus.query2_ready, q2r);
        if (q1r) chk("query1_value", bus.query1_value, q1v);
        if (q2r) chk("query2_value", bus.query2_value, q2v);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid    = 1'b0;
        bus.alloc_rd_index = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_data       = '0;
        bus.query1_tag     = '0;
        bus.query2_tag     = '0;
`ifdef ROB_FLUSH_EN
        bus.flush          = 1'b0;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    task automatic cdb(input logic [TW-1:0] t, input logic [XLEN-1:0] d);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_data  = d;
        cyc();
        bus.cdb_valid = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_count", bus.count, 0);
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_alloc_tag", bus.alloc_tag, 0);
        chk("rst_commit_valid", bus.commit_valid, 0);
        chk("rst_commit_tag", bus.commit_tag, 0);
        chk("rst_query1_ready", bus.query1_ready, 0);

        // single instruction: allocate, complete, retire
        cyc();
        bus.alloc_valid = 1'b1; bus.alloc_rd_index = 5'd3;
        #1;
        chk("t1_alloc_tag", bus.alloc_tag, 0);
        chk("t1_rob_entry_alloc", bus.rob_entry_alloc, 1);
        cyc();
        bus.alloc_valid = 1'b0; bus.query1_tag = '0;
        @(negedge clk);
        chk("t1_count", bus.count, 1);
        chk("t1_commit_pending", bus.commit_valid, 0);
        chk("t1_query_pending", bus.query1_ready, 0);
        cyc();
        cdb(4'd0, 32'h0123_4567);
        @(negedge clk);
        chk("t1_query_ready", bus.query1_ready, 1);
        chk("t1_query_value", bus.query1_value, 32'h0123_4567);
        chk("t1_commit_valid", bus.commit_valid, 1);
        chk("t1_commit_we", bus.commit_write_en, 1);
        chk("t1_commit_rd", bus.commit_rd_index, 3);
        chk("t1_commit_tag", bus.commit_tag, 0);
        cyc();
        @(negedge clk);
        chk("t1_count_after", bus.count, 0);

        // fill to capacity, then retire head and regrant with wrapped tag
        cyc();
        do_reset();
        bus.alloc_valid = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            bus.alloc_rd_index = 5'($urandom_range(1, 31));
            cyc();
        end
        @(negedge clk);
        chk("full_alloc_ready", bus.alloc_ready, 0);
        chk("full_count", bus.count, 16);
        chk("full_no_grant", bus.rob_entry_alloc, 0);
        cyc();
        cdb(4'd0, $urandom);
        @(negedge clk);
        chk("full_commit_valid", bus.commit_valid, 1);
        chk("full_still_blocked", bus.alloc_ready, 0);
        cyc();
        @(negedge clk);
        chk("full_regrant_ready", bus.alloc_ready, 1);
        chk("full_regrant_tag", bus.alloc_tag, 0);
        chk("full_regrant_alloc", bus.rob_entry_alloc, 1);
        cyc();
        bus.alloc_valid = 1'b0;
        @(negedge clk);
        chk("full_refill_count", bus.count, 16);

        // simultaneous allocate and commit at count==1
        cyc();
        do_reset();
        bus.alloc_valid = 1'b1; bus.alloc_rd_index = 5'd7;
        cyc();
        bus.alloc_valid = 1'b0;
        cdb(4'd0, 32'h5555_AAAA);
        bus.alloc_valid = 1'b1; bus.alloc_rd_index = 5'd9;
        @(negedge clk);
        chk("sim_commit", bus.commit_valid, 1);
        chk("sim_alloc", bus.rob_entry_alloc, 1);
        cyc();
        bus.alloc_valid = 1'b0;
        @(negedge clk);
        chk("sim_count", bus.count, 1);
        chk("sim_next_tag", bus.alloc_tag, 2);

        // out-of-order completion, in-order retirement
        cyc();
        do_reset();
        bus.alloc_valid = 1'b1; bus.alloc_rd_index = 5'd5;
        cyc();
        bus.alloc_rd_index = 5'd0;
        cyc();
        bus.alloc_valid = 1'b0;
        cdb(4'd1, 32'hAAAA_BBBB);
        @(negedge clk);
        chk("ooo_hold", bus.commit_valid, 0);
        cyc();
        cdb(4'd0, 32'h89AB_CDEF);
        @(negedge clk);
        chk("ooo_c0_valid", bus.commit_valid, 1);
        chk("ooo_c0_tag", bus.commit_tag, 0);
        chk("ooo_c0_data", bus.commit_data, 32'h89AB_CDEF);
        chk("ooo_c0_we", bus.commit_write_en, 1);
        cyc();
        @(negedge clk);
        chk("ooo_c1_valid", bus.commit_valid, 1);
        chk("ooo_c1_tag", bus.commit_tag, 1);
        chk("ooo_c1_data", bus.commit_data, 32'hAAAA_BBBB);
        chk("ooo_c1_we", bus.commit_write_en, 0);

        // asynchronous reset with live entries
        cyc();
        do_reset();
        bus.alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.alloc_rd_index = 5'(i + 1);
            cyc();
        end
        bus.alloc_valid = 1'b0;
        cdb(4'd0, 32'h1234_0000);
        #2 reset = 1'b0;
        #1;
        chk("areset_count", bus.count, 0);
        chk("areset_commit", bus.commit_valid, 0);
        chk("areset_alloc_tag", bus.alloc_tag, 0);
        cyc();
        reset = 1'b1;

`ifdef ROB_FLUSH_EN
        // flush discards everything, including a ready head
        cyc();
        bus.alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.alloc_rd_index = 5'(i + 2);
            cyc();
        end
        bus.alloc_valid = 1'b0;
        cdb(4'd0, 32'hF00D_F00D);
        bus.flush = 1'b1;
        #1;
        chk("flush_commit_masked", bus.commit_valid, 0);
        cyc();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_count", bus.count, 0);
        chk("flush_alloc_tag", bus.alloc_tag, 0);
        chk("flush_commit", bus.commit_valid, 0);
`endif

        // randomized traffic
        cyc();
        for (int n = 0; n < 3000; n++) begin
            int pct;
            pct = (n < 1500) ? 70 : 40;
            if (reset == 1'b0) reset = 1'b1;
            else if ($urandom_range(0, 999) < 3) reset = 1'b0;
            bus.alloc_valid    = ($urandom_range(0, 99) < pct);
            bus.alloc_rd_index = 5'($urandom_range(0, 31));
            bus.cdb_data       = $urandom;
            if (rob_m.size() > 0 && $urandom_range(0, 99) < 50) begin
                bus.cdb_valid = 1'b1;
                bus.cdb_tag   = rob_m[$urandom_range(0, rob_m.size() - 1)].tag;
            end else if ($urandom_range(0, 99) < 10) begin
                bus.cdb_valid = 1'b1;
                bus.cdb_tag   = TW'($urandom_range(0, SIZE - 1));
            end else begin
                bus.cdb_valid = 1'b0;
            end
            bus.query1_tag = TW'($urandom_range(0, SIZE - 1));
            bus.query2_tag = (rob_m.size() > 0) ? rob_m[$urandom_range(0, rob_m.size() - 1)].tag
                                                : TW'($urandom_range(0, SIZE - 1));
`ifdef ROB_FLUSH_EN
            bus.flush = ($urandom_range(0, 99) < 1);
`endif
            cyc();
        end
        idle();
        reset = 1'b1;
        repeat (4) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
